// File: rtl/chan_demux.sv
// chan_demux: pops header+payload bursts from a non-showahead FIFO and steers each payload
// word into one of CHANNELS_USED per-channel FIFOs. Define CHAN_DEMUX_ERR_EN to drive err.
module chan_demux #(
    parameter int CHANNELS_USED = 3,
    parameter int DATA_WIDTH    = 16,
    parameter int LEN_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     src_rdreq,
    input  logic [DATA_WIDTH-1:0]    src_data,
    input  logic                     src_empty,
    output logic [CHANNELS_USED-1:0] ch_wrreq,
    output logic [DATA_WIDTH-1:0]    ch_data,
    input  logic [CHANNELS_USED-1:0] ch_full,
    output logic                     busy,
    output logic                     err
);
    localparam int CH_W = $clog2(CHANNELS_USED);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t                   state, state_nxt;
    logic [CH_W-1:0]          ch;
    logic [LEN_WIDTH-1:0]     len;
    logic [LEN_WIDTH-1:0]     issued;
    logic                     discard;
    logic                     rd_valid;
    logic                     hold_valid;
    logic [DATA_WIDTH-1:0]    hold;

    logic [CH_W-1:0]          hdr_ch;
    logic [LEN_WIDTH-1:0]     hdr_len;
    logic                     hdr_bad;
    logic [CHANNELS_USED-1:0] ch_sel;
    logic                     sel_full;
    logic                     pop;
    logic                     hold_load;
    logic                     hold_clear;
    logic                     consumed;
    logic                     pending;

    assign hdr_ch  = src_data[CH_W-1:0];
    assign hdr_len = src_data[DATA_WIDTH-1 -: LEN_WIDTH];
    assign hdr_bad = ({1'b0, hdr_ch} >= (CH_W+1)'(CHANNELS_USED));

    // An out-of-range index shifts the bit out, so ch_sel is all-zero for a discarded burst.
    assign ch_sel   = {{(CHANNELS_USED-1){1'b0}}, 1'b1} << ch;
    assign sel_full = |(ch_full & ch_sel);

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        ch_wrreq   = '0;
        ch_data    = '0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        consumed   = 1'b0;
        pending    = 1'b0;

        case (state)
            IDLE: begin
                pop = !src_empty;
                if (pop) state_nxt = HDR;
            end
            HDR: begin
                state_nxt = (hdr_len == '0) ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
                pop = (issued != len) && !src_empty && !hold_valid && (discard || !sel_full);
                // The held word is older than anything in flight, so it drains first.
                if (hold_valid) begin
                    if (!sel_full) begin
                        ch_wrreq   = ch_sel;
                        ch_data    = hold;
                        hold_clear = 1'b1;
                        consumed   = 1'b1;
                    end
                end else if (rd_valid) begin
                    if (discard) begin
                        consumed = 1'b1;
                    end else if (!sel_full) begin
                        ch_wrreq = ch_sel;
                        ch_data  = src_data;
                        consumed = 1'b1;
                    end else begin
                        hold_load = 1'b1;
                    end
                end
                pending = (hold_valid || rd_valid) && !consumed;
                if ((issued == len) && !pending) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (reset) begin
            pop        = 1'b0;
            ch_wrreq   = '0;
            ch_data    = '0;
            hold_load  = 1'b0;
            hold_clear = 1'b0;
        end
    end

    assign src_rdreq = pop;
    assign busy      = (state != IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ch         <= '0;
            len        <= '0;
            issued     <= '0;
            discard    <= 1'b0;
            rd_valid   <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= pop;
            if (state == HDR) begin
                ch      <= hdr_ch;
                len     <= hdr_len;
                issued  <= '0;
                discard <= hdr_bad;
            end else if (pop && (state == PAYLOAD)) begin
                issued <= issued + 1'b1;
            end
            if (hold_load) begin
                hold_valid <= 1'b1;
            end else if (hold_clear) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Hold data is qualified by hold_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (hold_load) hold <= src_data;
    end

`ifdef CHAN_DEMUX_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((state == HDR) && hdr_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/chan_demux.md
# chan_demux

Single-clock channel demultiplexer: the receive-side counterpart of the channel multiplexer. It pops a tagged burst stream from an upstream non-showahead FIFO and writes each burst's payload into one of `CHANNELS_USED` per-channel FIFOs. It sits between the common link FIFO and the per-channel consumers, and applies per-channel backpressure without losing words.

## Interface
- `CHANNELS_USED`, 3: number of output channels; must be ≥2.
- `DATA_WIDTH`, 16: word width.
- `LEN_WIDTH`, 8: width of the burst-length field; must be ≤ `DATA_WIDTH - CH_W`, where `CH_W = $clog2(CHANNELS_USED)`.

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `src_rdreq` out 1: pop request to the upstream FIFO.
- `src_data` in `DATA_WIDTH`: upstream word; valid the cycle after `src_rdreq`.
- `src_empty` in 1: upstream FIFO empty.
- `ch_wrreq` out `CHANNELS_USED`: one-hot write strobe, combinational.
- `ch_data` out `DATA_WIDTH`: shared write data, combinational.
- `ch_full` in `CHANNELS_USED`: per-channel FIFO full flags.
- `busy` out 1: high whenever state ≠ IDLE.
- `err` out 1: sticky flag for an invalid channel header.

## Operation
- Stream format: each burst is one header word followed by `len` payload words.
  - Header `[CH_W-1:0]` is the channel index.
  - Header `[DATA_WIDTH-1 -: LEN_WIDTH]` is `len`.
  - `len` = 0 is a no-op header.
- `rd_valid` is `src_rdreq` registered by one cycle and marks when `src_data` is valid.
- FSM states are IDLE, HDR and PAYLOAD.
  - IDLE: `src_rdreq = !src_empty`. On a pop, go to HDR.
  - HDR: `src_rdreq = 0`. Capture `ch`, `len` and `issued = 0`.
    - If `len` = 0, go to IDLE.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: `src_rdreq = (issued != len) && !src_empty && !hold_valid && (discard || !ch_full[ch])`.
    - `issued` increments on each pop.
- Write path in PAYLOAD, with the hold register taking priority:
  - `hold_valid`: drive `ch_data = hold`. Assert `ch_wrreq[ch]` when `!ch_full[ch]`, which clears `hold_valid`.
  - Otherwise, on `rd_valid`: drive `ch_data = src_data`.
    - If `!ch_full[ch]`, assert `ch_wrreq[ch]`.
    - Else load the word into `hold` and set `hold_valid`.
  - `ch_data` = 0 when no strobe is active.
- Exit PAYLOAD to IDLE when `issued == len` and no word is pending.
  - A word is pending if `hold_valid` is set, or `rd_valid` is set without a write this cycle.
  - The last word written this cycle does not count as pending.
- Discard: when the header channel is ≥ `CHANNELS_USED`, `discard` is set.
  - The payload is popped and dropped; `ch_wrreq` stays 0.
  - `err` handling depends on the macro (see Configuration).
- Words are never duplicated or lost under any `ch_full` pattern. Output order equals input order per channel.
- The header word itself is never written to a channel.

## Timing
- Reset values:
  - State IDLE; `issued`, `len`, `ch`, `hold_valid`, `rd_valid` and `err` are all 0.
  - While `reset` is high, `src_rdreq`, `ch_wrreq` and `busy` are forced to 0.
- Reset mid-burst abandons the burst; any in-flight or held word is discarded.
- Unstalled burst, with the header pop at cycle t:
  - Header is on `src_data` at t+1.
  - First payload pop is at t+2; first `ch_wrreq` is at t+3.
  - Last `ch_wrreq` is at t+2+len.
  - IDLE and the next header pop are at t+3+len.
  - Throughput is len words per len+3 cycles.
- `ch_full` is sampled the same cycle as the strobe. A FIFO whose full flag updates one cycle after `wrreq` cannot overflow.
- At most one word is in flight beyond `hold`. `src_rdreq` is never asserted while `hold_valid` is set.
- `src_empty` toggling mid-burst only inserts idle cycles.

## Configuration
- Macro: `CHAN_DEMUX_ERR_EN`.
- Defined: the out-of-range channel check drives `err`.
  - `err` sets the cycle after HDR captures a bad index.
  - It stays set until `reset`.
- Undefined: `err` is tied to 0. Out-of-range bursts are still silently drained.

## Test plan
- Nominal burst: `CHANNELS_USED`=3; header ch=1, len=4; payload 0xA1..0xA4, `ch_full`=0.
  - Required: `ch_wrreq`=3'b010 on four consecutive cycles with data A1..A4, starting 3 cycles after the header pop.
  - Required: `busy` drops 1 cycle after the last write.
- Backpressure:
  - Stimulus: ch=2, len=5; `ch_full[2]` raised for 6 cycles after the 2nd write.
  - Required: exactly 5 writes in order. The word hitting full is held and then written first once full clears. No `src_rdreq` while held.
- Zero-length and back-to-back:
  - Stimulus: header len=0, immediately followed by ch=0 len=2.
  - Required: no writes for the first header; two writes on ch0; `busy` never sticks.
- Invalid channel:
  - Stimulus: ch=3, len=3, followed by ch=0 len=1.
  - Required: 3 payload words popped and dropped; the single word is written to ch0.
  - Required: `err`=1 with `CHAN_DEMUX_ERR_EN` defined, 0 without it.
- Reset mid-burst:
  - Stimulus: assert `reset` for 1 cycle after 2 of len=6 words, while a word is held.
  - Required: all outputs 0 during reset; FSM in IDLE after; the next header is parsed correctly.
- Starved source:
  - Stimulus: `src_empty` toggled randomly during a len=8 burst.
  - Required: all 8 words delivered in order; no pop while empty.
